// File: rtl/if_id_pipeline.sv
// if_id_pipeline: IF and ID stages of a 5-stage MIPS pipeline up to the ID/EX register.
// Holds PC, instruction ROM, IF/ID, 32x32 register file, control decoder and sign extender.
module if_id_pipeline #(
    parameter int IMEM_DEPTH = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PCSrc,
    input  logic [31:0] EX_MEM_NPC,
    input  logic        RegWrite,
    input  logic [4:0]  MEM_WB_Writereg,
    input  logic [31:0] MEM_WB_Writedata,
    output logic [8:0]  control_bits_out,
    output logic [31:0] IF_ID_NPC_To_EX_MEM,
    output logic [31:0] TO_EX_ALU,
    output logic [31:0] To_EX_MUX0_and_EX_MEM,
    output logic [31:0] signExtended,
    output logic [4:0]  EX_Mux_0,
    output logic [4:0]  EX_Mux_1
);
    localparam int AW = $clog2(IMEM_DEPTH);

    logic [31:0] pc_q, pc_d, instr_q, npc_q, rom_word;
    logic        valid_q;
    logic [31:0] regs_q [32];
    logic [AW-1:0] pc_idx;
    logic [5:0]  opcode;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rs_data, rt_data, sext;
    logic [8:0]  ctrl;

    assign pc_idx = pc_q[AW-1:0];
    assign pc_d   = PCSrc ? EX_MEM_NPC : pc_q + 32'd1;

    always_comb begin
        rom_word = (pc_idx == AW'(0)) ? 32'h00221820 :
                   (pc_idx == AW'(1)) ? 32'h8C640004 :
                   (pc_idx == AW'(2)) ? 32'hAC85FFFC :
                   (pc_idx == AW'(3)) ? 32'h10860002 : 32'h0;
    end

    assign opcode = instr_q[31:26];
    assign rs     = instr_q[25:21];
    assign rt     = instr_q[20:16];
    assign rd     = instr_q[15:11];
    assign sext   = {{16{instr_q[15]}}, instr_q[15:0]};

    // IF/ID is empty straight after reset; its all-zero word must not decode as R-type
    always_comb begin
        ctrl = !valid_q               ? 9'b000000000 :
               (opcode == 6'b000000) ? 9'b110000010 :
               (opcode == 6'b100011) ? 9'b000101011 :
               (opcode == 6'b101011) ? 9'b000100100 :
               (opcode == 6'b000100) ? 9'b001010000 : 9'b000000000;
    end

    // Write-through lets ID see a value retiring from WB in the same cycle
    always_comb begin
        rs_data = (rs == 5'd0) ? 32'd0 :
                  (RegWrite && MEM_WB_Writereg == rs) ? MEM_WB_Writedata : regs_q[rs];
        rt_data = (rt == 5'd0) ? 32'd0 :
                  (RegWrite && MEM_WB_Writereg == rt) ? MEM_WB_Writedata : regs_q[rt];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q    <= 32'd0;
            instr_q <= 32'd0;
            npc_q   <= 32'd0;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= rom_word;
            npc_q   <= pc_q + 32'd1;
            valid_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= 32'(i);
        end else if (RegWrite && MEM_WB_Writereg != 5'd0) begin
            regs_q[MEM_WB_Writereg] <= MEM_WB_Writedata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            control_bits_out      <= 9'd0;
            IF_ID_NPC_To_EX_MEM   <= 32'd0;
            TO_EX_ALU             <= 32'd0;
            To_EX_MUX0_and_EX_MEM <= 32'd0;
            signExtended          <= 32'd0;
            EX_Mux_0              <= 5'd0;
            EX_Mux_1              <= 5'd0;
        end else begin
            control_bits_out      <= ctrl;
            IF_ID_NPC_To_EX_MEM   <= npc_q;
            TO_EX_ALU             <= rs_data;
            To_EX_MUX0_and_EX_MEM <= rt_data;
            signExtended          <= sext;
            EX_Mux_0              <= rt;
            EX_Mux_1              <= rd;
        end
    end
endmodule

// File: tb/tb_if_id_pipeline.sv
// tb_if_id_pipeline: directed and randomized checks of if_id_pipeline against a
// fetch-queue reference model.
module tb_if_id_pipeline;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        PCSrc = 1'b0;
    logic [31:0] EX_MEM_NPC = 32'd0;
    logic        RegWrite = 1'b0;
    logic [4:0]  MEM_WB_Writereg = 5'd0;
    logic [31:0] MEM_WB_Writedata = 32'd0;
    logic [8:0]  control_bits_out;
    logic [31:0] IF_ID_NPC_To_EX_MEM, TO_EX_ALU, To_EX_MUX0_and_EX_MEM, signExtended;
    logic [4:0]  EX_Mux_0, EX_Mux_1;

    int checks = 0;
    int errors = 0;

    if_id_pipeline #(.IMEM_DEPTH(32)) dut (
        .clk(clk), .reset(reset), .PCSrc(PCSrc), .EX_MEM_NPC(EX_MEM_NPC),
        .RegWrite(RegWrite), .MEM_WB_Writereg(MEM_WB_Writereg),
        .MEM_WB_Writedata(MEM_WB_Writedata), .control_bits_out(control_bits_out),
        .IF_ID_NPC_To_EX_MEM(IF_ID_NPC_To_EX_MEM), .TO_EX_ALU(TO_EX_ALU),
        .To_EX_MUX0_and_EX_MEM(To_EX_MUX0_and_EX_MEM), .signExtended(signExtended),
        .EX_Mux_0(EX_Mux_0), .EX_Mux_1(EX_Mux_1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] npc;
    } fetch_t;

    fetch_t      fq[$];
    logic [31:0] rom_m [32];
    logic [31:0] m_regs [32];
    logic [31:0] m_pc;
    logic [8:0]  e_ctrl;
    logic [31:0] e_npc, e_rs, e_rt, e_sext;
    logic [4:0]  e_m0, e_m1;

    function automatic logic [8:0] ctrl_of(input logic [5:0] op);
        case (op)
            6'b000000: return 9'b110000010;
            6'b100011: return 9'b000101011;
            6'b101011: return 9'b000100100;
            6'b000100: return 9'b001010000;
            default:   return 9'b000000000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [8:0] c, input logic [31:0] n,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] s,
                       input logic [4:0] m0, input logic [4:0] m1);
        checks++;
        assert (control_bits_out === c) else begin
            errors++; $error("FAIL %s ctrl got %b exp %b", tag, control_bits_out, c);
        end
        checks++;
        assert (IF_ID_NPC_To_EX_MEM === n) else begin
            errors++; $error("FAIL %s npc got %0h exp %0h", tag, IF_ID_NPC_To_EX_MEM, n);
        end
        checks++;
        assert (TO_EX_ALU === a) else begin
            errors++; $error("FAIL %s rs got %0h exp %0h", tag, TO_EX_ALU, a);
        end
        checks++;
        assert (To_EX_MUX0_and_EX_MEM === b) else begin
            errors++; $error("FAIL %s rt got %0h exp %0h", tag, To_EX_MUX0_and_EX_MEM, b);
        end
        checks++;
        assert (signExtended === s) else begin
            errors++; $error("FAIL %s sext got %0h exp %0h", tag, signExtended, s);
        end
        checks++;
        assert (EX_Mux_0 === m0) else begin
            errors++; $error("FAIL %s mux0 got %0d exp %0d", tag, EX_Mux_0, m0);
        end
        checks++;
        assert (EX_Mux_1 === m1) else begin
            errors++; $error("FAIL %s mux1 got %0d exp %0d", tag, EX_Mux_1, m1);
        end
    endtask

    task automatic chk_model(input string tag);
        chk(tag, e_ctrl, e_npc, e_rs, e_rt, e_sext, e_m0, e_m1);
    endtask

    task automatic m_reset();
        fq.delete();
        m_pc = 32'd0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'(i);
        {e_ctrl, e_npc, e_rs, e_rt, e_sext, e_m0, e_m1} = '0;
    endtask

    // Instruction fetched one edge ago reaches ID/EX now; reads observe this cycle's write.
    task automatic step(input logic pcsrc, input logic [31:0] npc, input logic rw,
                        input logic [4:0] wr, input logic [31:0] wd);
        fetch_t f;
        PCSrc = pcsrc; EX_MEM_NPC = npc; RegWrite = rw;
        MEM_WB_Writereg = wr; MEM_WB_Writedata = wd;
        if (rw && wr != 5'd0) m_regs[wr] = wd;
        if (fq.size() > 0) begin
            f = fq.pop_front();
            e_ctrl = ctrl_of(f.instr[31:26]);
            e_npc  = f.npc;
            e_rs   = m_regs[f.instr[25:21]];
            e_rt   = m_regs[f.instr[20:16]];
            e_sext = 32'($signed(f.instr[15:0]));
            e_m0   = f.instr[20:16];
            e_m1   = f.instr[15:11];
        end else begin
            {e_ctrl, e_npc, e_rs, e_rt, e_sext, e_m0, e_m1} = '0;
        end
        fq.push_back('{instr: rom_m[m_pc[4:0]], npc: m_pc + 32'd1});
        m_pc = pcsrc ? npc : m_pc + 32'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk(tag, 9'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0);
        m_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rom_m[i] = 32'd0;
        rom_m[0] = 32'h00221820;
        rom_m[1] = 32'h8C640004;
        rom_m[2] = 32'hAC85FFFC;
        rom_m[3] = 32'h10860002;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset", 9'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0);
        reset = 1'b1;

        step(0, 0, 0, 0, 0);
        chk("edge1", 9'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0);
        step(0, 0, 0, 0, 0);
        chk("add", 9'b110000010, 32'd1, 32'd1, 32'd2, 32'd6176, 5'd2, 5'd3);
        step(0, 0, 0, 0, 0);
        chk("lw", 9'b000101011, 32'd2, 32'd3, 32'd4, 32'd4, 5'd4, 5'd0);
        step(0, 0, 0, 0, 0);
        chk("sw", 9'b000100100, 32'd3, 32'd4, 32'd5, 32'hFFFFFFFC, 5'd5, 5'd31);
        step(0, 0, 0, 0, 0);
        chk("beq", 9'b001010000, 32'd4, 32'd4, 32'd6, 32'd2, 5'd6, 5'd0);
        step(0, 0, 0, 0, 0);
        chk("nop", 9'b110000010, 32'd5, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0);
        chk_model("nop_model");

        do_reset("async_rst");
        step(0, 0, 0, 0, 0);
        chk("rst_edge1", 9'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0);
        step(0, 0, 1, 2, 100);
        chk("bypass", 9'b110000010, 32'd1, 32'd1, 32'd100, 32'd6176, 5'd2, 5'd3);
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 1, 0, 55);
            chk_model("zero_wr");
        end
        chk("zero_reg", 9'b110000010, 32'd5, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0);

        do_reset("async_rst2");
        step(1, 2, 0, 0, 0);
        chk("br_edge1", 9'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0);
        step(0, 0, 0, 0, 0);
        chk("br_add", 9'b110000010, 32'd1, 32'd1, 32'd2, 32'd6176, 5'd2, 5'd3);
        step(0, 0, 0, 0, 0);
        chk("br_sw", 9'b000100100, 32'd3, 32'd4, 32'd5, 32'hFFFFFFFC, 5'd5, 5'd31);

        for (int k = 0; k < 400; k++) begin
            logic [31:0] tgt;
            tgt = ($urandom_range(0, 9) == 0) ? 32'hFFFFFFFF : 32'($urandom_range(0, 63));
            if (k % 97 == 96) do_reset("rand_rst");
            step($urandom_range(0, 5) == 0, tgt, 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 31)), $urandom);
            chk_model("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
